// File: rtl/dmem_unit.sv
// dmem_unit: MIPS data-memory stage with a WAIT_CYCLES-latency access FSM, stall handshake,
// little-endian byte/half/word access and misalignment detection. Optional store buffer: DMEM_STORE_BUF_EN.
module dmem_unit #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  input  logic        i_req_write,
  input  logic [1:0]  i_req_size,
  input  logic        i_req_unsigned,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_stall,
  output logic [31:0] o_rdata,
  output logic        o_rdata_valid,
  output logic        o_misalign_err
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t      r_state, w_nextState;
  logic [3:0]  r_waitCnt;
  logic        r_reqWrite;
  logic [1:0]  r_reqSize;
  logic        r_reqUnsigned;
  logic [AW+1:0] r_reqAddr;
  logic [31:0] r_reqWdata;
  logic [31:0] r_rdataHold;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic          w_accept, w_bufCapture, w_reqMisaligned, w_regMisaligned;
  logic          w_fsmCommit, w_loadDone, w_memWe, w_unusedAddr;
  logic [AW-1:0] w_memIdx;
  logic [31:0]   w_memData, w_loadData;

  function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] lo);
    logic res;
    case (size)
      2'b00:   res = 1'b0;
      2'b01:   res = lo[0];
      default: res = (lo != 2'b00);
    endcase
    return res;
  endfunction

  function automatic logic [31:0] mergeStore(input logic [31:0] old, input logic [31:0] wd,
                                             input logic [1:0] size, input logic [1:0] lo);
    logic [31:0] res;
    res = old;
    case (size)
      2'b00:   res[{lo, 3'b000} +: 8] = wd[7:0];
      2'b01:   res[{lo[1], 4'b0000} +: 16] = wd[15:0];
      default: res = wd;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] loadExtend(input logic [31:0] word, input logic [1:0] size,
                                             input logic [1:0] lo, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b = word[{lo, 3'b000} +: 8];
    h = word[{lo[1], 4'b0000} +: 16];
    case (size)
      2'b00:   res = uns ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   res = uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: res = word;
    endcase
    return res;
  endfunction

  // Address bits above the array index are ignored, so accesses wrap.
  assign w_unusedAddr    = ^i_addr[31:AW+2];
  assign w_reqMisaligned = isMisaligned(i_req_size, i_addr[1:0]);
  assign w_regMisaligned = isMisaligned(r_reqSize, r_reqAddr[1:0]);
  assign w_fsmCommit     = (r_state == S_DONE) && r_reqWrite && !w_regMisaligned;
  assign w_loadDone      = (r_state == S_DONE) && !r_reqWrite && !w_regMisaligned;
  assign w_loadData      = loadExtend(r_mem[r_reqAddr[AW+1:2]], r_reqSize, r_reqAddr[1:0], r_reqUnsigned);

`ifdef DMEM_STORE_BUF_EN
  logic          r_bufValid;
  logic [3:0]    r_bufCnt;
  logic [AW+1:0] r_bufAddr;
  logic [1:0]    r_bufSize;
  logic [31:0]   r_bufData;
  logic          w_bufDrain;

  assign w_bufCapture = (r_state == S_IDLE) && i_req_valid && i_req_write && !w_reqMisaligned && !r_bufValid;
  assign w_bufDrain   = r_bufValid && (r_bufCnt == 4'(WAIT_CYCLES));
  assign w_accept     = (r_state == S_IDLE) && i_req_valid && !r_bufValid && !w_bufCapture;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_bufValid <= 1'b0;
      r_bufCnt   <= '0;
      r_bufAddr  <= '0;
      r_bufSize  <= '0;
      r_bufData  <= '0;
    end else if (w_bufCapture) begin
      r_bufValid <= 1'b1;
      r_bufCnt   <= '0;
      r_bufAddr  <= i_addr[AW+1:0];
      r_bufSize  <= i_req_size;
      r_bufData  <= i_wdata;
    end else if (w_bufDrain) begin
      r_bufValid <= 1'b0;
    end else if (r_bufValid) begin
      r_bufCnt <= r_bufCnt + 4'd1;
    end
  end

  // Requests are held off while draining, so the two write sources never collide.
  assign w_memWe   = w_fsmCommit || w_bufDrain;
  assign w_memIdx  = w_bufDrain ? r_bufAddr[AW+1:2] : r_reqAddr[AW+1:2];
  assign w_memData = w_bufDrain ? mergeStore(r_mem[w_memIdx], r_bufData, r_bufSize, r_bufAddr[1:0])
                                : mergeStore(r_mem[w_memIdx], r_reqWdata, r_reqSize, r_reqAddr[1:0]);
`else
  assign w_bufCapture = 1'b0;
  assign w_accept     = (r_state == S_IDLE) && i_req_valid;
  assign w_memWe      = w_fsmCommit;
  assign w_memIdx     = r_reqAddr[AW+1:2];
  assign w_memData    = mergeStore(r_mem[w_memIdx], r_reqWdata, r_reqSize, r_reqAddr[1:0]);
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_waitCnt     <= '0;
      r_reqWrite    <= 1'b0;
      r_reqSize     <= '0;
      r_reqUnsigned <= 1'b0;
      r_reqAddr     <= '0;
      r_reqWdata    <= '0;
      r_rdataHold   <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_accept) begin
        r_waitCnt     <= '0;
        r_reqWrite    <= i_req_write;
        r_reqSize     <= i_req_size;
        r_reqUnsigned <= i_req_unsigned;
        r_reqAddr     <= i_addr[AW+1:0];
        r_reqWdata    <= i_wdata;
      end else if (r_state == S_WAIT) begin
        r_waitCnt <= r_waitCnt + 4'd1;
      end
      if (w_loadDone) r_rdataHold <= w_loadData;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_nextState = (WAIT_CYCLES > 0) ? S_WAIT : S_DONE;
      S_WAIT:  if (r_waitCnt == WAIT_LAST) w_nextState = S_DONE;
      S_DONE:  w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  // Reset gates the write so an access aborted by reset never commits.
  always_ff @(posedge i_clk) begin
    if (w_memWe && !i_rst) r_mem[w_memIdx] <= w_memData;
  end

  assign o_stall        = ((r_state == S_IDLE) && i_req_valid && !w_bufCapture) || (r_state == S_WAIT);
  assign o_rdata        = w_loadDone ? w_loadData : r_rdataHold;
  assign o_rdata_valid  = w_loadDone;
  assign o_misalign_err = (r_state == S_DONE) && w_regMisaligned;

endmodule

// File: tb/tb_dmem_unit.sv
// tb_dmem_unit: directed and randomized checks of dmem_unit against a byte-addressed reference model.
module tb_dmem_unit;
  localparam int WAIT  = 2;
  localparam int DEPTH = 256;
  localparam int BYTES = DEPTH * 4;
`ifdef DMEM_STORE_BUF_EN
  localparam bit BUF_EN = 1'b1;
`else
  localparam bit BUF_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        reqValid, reqWrite, reqUnsigned;
  logic [1:0]  reqSize;
  logic [31:0] addr, wdata;
  logic        stall, rdataValid, misalignErr;
  logic [31:0] rdata;

  int          testsRun = 0;
  int          testsFailed = 0;
  logic [7:0]  modelMem [BYTES];
  logic [31:0] lastRdata = '0;

  dmem_unit #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAIT)) dut (
    .i_clk(clk), .i_rst(rst), .i_req_valid(reqValid), .i_req_write(reqWrite),
    .i_req_size(reqSize), .i_req_unsigned(reqUnsigned), .i_addr(addr), .i_wdata(wdata),
    .o_stall(stall), .o_rdata(rdata), .o_rdata_valid(rdataValid), .o_misalign_err(misalignErr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  function automatic logic modelMisaligned(input logic [1:0] sz, input logic [31:0] a);
    int align;
    align = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    return (a % align) != 0;
  endfunction

  function automatic int sizeBytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] modelLoad(input logic [1:0] sz, input logic uns, input logic [31:0] a);
    int     base, n;
    longint v;
    base = int'(a % BYTES);
    n = sizeBytes(sz);
    v = 0;
    for (int i = n - 1; i >= 0; i--) v = v * 256 + longint'(modelMem[(base + i) % BYTES]);
    if (!uns && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  task automatic modelStore(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    int base;
    base = int'(a % BYTES);
    for (int i = 0; i < sizeBytes(sz); i++) modelMem[(base + i) % BYTES] = wd[8 * i +: 8];
  endtask

  // One core access: hold the request while stalled, scramble inputs once accepted, then idle for gap cycles.
  task automatic applyStimulus(input logic wr, input logic [1:0] sz, input logic uns, input logic [31:0] a,
                               input logic [31:0] wd, input int gap, input int extraStall);
    int          stallCnt, validCnt, errCnt, cyc, expStall;
    logic [31:0] seenRdata, expLoad;
    logic        mis, done;
    mis      = modelMisaligned(sz, a);
    expLoad  = modelLoad(sz, uns, a);
    expStall = ((BUF_EN && wr && !mis) ? 0 : WAIT + 1) + extraStall;
    reqValid = 1'b1; reqWrite = wr; reqSize = sz; reqUnsigned = uns; addr = a; wdata = wd;
    stallCnt = 0; validCnt = 0; errCnt = 0; cyc = 0; done = 1'b0; seenRdata = '0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      if (stall) stallCnt++; else done = 1'b1;
      if (rdataValid) begin validCnt++; seenRdata = rdata; end
      if (misalignErr) errCnt++;
      @(posedge clk); #1;
      cyc++;
      if (!done && extraStall == 0) begin
        reqWrite = 1'($urandom); reqSize = 2'($urandom); reqUnsigned = 1'($urandom);
        addr = $urandom; wdata = $urandom;
      end
    end
    reqValid = 1'b0;
    checkOutput("accessDone", {31'd0, done}, 32'd1);
    checkOutput("stallCycles", stallCnt, expStall);
    checkOutput("misalignPulses", errCnt, mis ? 32'd1 : 32'd0);
    checkOutput("validPulses", validCnt, (!wr && !mis) ? 32'd1 : 32'd0);
    if (!wr && !mis) begin
      checkOutput("loadData", seenRdata, expLoad);
      lastRdata = expLoad;
    end
    if (wr && !mis) modelStore(sz, a, wd);
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      checkOutput("idlePulses", {30'd0, rdataValid, misalignErr}, 32'd0);
      @(posedge clk); #1;
    end
    checkOutput("rdataHold", rdata, lastRdata);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          gapN;
    logic [31:0] ra;
    gapN = BUF_EN ? WAIT + 2 : 1;
    for (int i = 0; i < BYTES; i++) modelMem[i] = 8'h00;
    rst = 1'b1; reqValid = 1'b0; reqWrite = 1'b0; reqSize = 2'd0; reqUnsigned = 1'b0; addr = '0; wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("resetStall", {31'd0, stall}, 32'd0);
    checkOutput("resetRdata", rdata, 32'd0);
    checkOutput("resetValid", {31'd0, rdataValid}, 32'd0);
    checkOutput("resetMisalign", {31'd0, misalignErr}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 2'd2, 1'b0, i * 4, 32'd0, gapN, 0);

    applyStimulus(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, gapN, 0);
    applyStimulus(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, gapN, 0);
    checkOutput("wordLoad", rdata, 32'hDEADBEEF);

    applyStimulus(1'b1, 2'd2, 1'b0, 32'h10, 32'h0, gapN, 0);
    applyStimulus(1'b1, 2'd0, 1'b0, 32'h11, 32'h000000A5, gapN, 0);
    applyStimulus(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, gapN, 0);
    checkOutput("byteStoreWord", rdata, 32'h0000A500);
    applyStimulus(1'b0, 2'd0, 1'b0, 32'h11, 32'h0, gapN, 0);
    checkOutput("byteSigned", rdata, 32'hFFFFFFA5);
    applyStimulus(1'b0, 2'd0, 1'b1, 32'h11, 32'h0, gapN, 0);
    checkOutput("byteUnsigned", rdata, 32'h000000A5);

    applyStimulus(1'b1, 2'd2, 1'b0, 32'h20, 32'h0000CAFE, gapN, 0);
    applyStimulus(1'b1, 2'd1, 1'b0, 32'h22, 32'h00008001, gapN, 0);
    applyStimulus(1'b0, 2'd1, 1'b0, 32'h22, 32'h0, gapN, 0);
    checkOutput("halfSigned", rdata, 32'hFFFF8001);
    applyStimulus(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, gapN, 0);
    checkOutput("halfStoreWord", rdata, 32'h8001CAFE);

    applyStimulus(1'b1, 2'd2, 1'b0, 32'h13, 32'h12345678, gapN, 0);
    applyStimulus(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, gapN, 0);
    checkOutput("misalignNoWrite", rdata, 32'h0000A500);

    applyStimulus(1'b1, 2'd2, 1'b0, 32'h400, 32'h55AA33CC, gapN, 0);
    applyStimulus(1'b0, 2'd2, 1'b0, 32'h000, 32'h0, gapN, 0);
    checkOutput("wrapLoad", rdata, 32'h55AA33CC);

    // Abort a store with reset while it is still pending.
    reqValid = 1'b1; reqWrite = 1'b1; reqSize = 2'd2; reqUnsigned = 1'b0; addr = 32'h3C; wdata = 32'h77777777;
    @(posedge clk); #1;
    reqValid = 1'b0;
    @(posedge clk); #1;
    if (!BUF_EN) checkOutput("stallInWait", {31'd0, stall}, 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("midResetStall", {31'd0, stall}, 32'd0);
    checkOutput("midResetRdata", rdata, 32'd0);
    checkOutput("midResetValid", {31'd0, rdataValid}, 32'd0);
    checkOutput("midResetMisalign", {31'd0, misalignErr}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    lastRdata = '0;
    applyStimulus(1'b0, 2'd2, 1'b0, 32'h3C, 32'h0, gapN, 0);
    checkOutput("abortedStore", rdata, 32'h00000000);

    if (BUF_EN) begin
      applyStimulus(1'b1, 2'd2, 1'b0, 32'h30, 32'hCAFEF00D, 0, 0);
      applyStimulus(1'b0, 2'd2, 1'b0, 32'h30, 32'h0, gapN, WAIT + 1);
      checkOutput("bufferedLoad", rdata, 32'hCAFEF00D);
    end

    for (int i = 0; i < 200; i++) begin
      ra = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 63));
      applyStimulus(1'($urandom), 2'($urandom), 1'($urandom), ra, $urandom,
                    BUF_EN ? WAIT + 2 : $urandom_range(0, 2), 0);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
